// File: rtl/mawg_pkg.sv
// Shared types and constants for the waveform profile sequencer.
// Holds FSM states, select codes and the packed profile layout.
package mawg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_DWELL
  } state_t;

  localparam logic [1:0] OUT_SEL_WAVE  = 2'b00;
  localparam logic [1:0] OUT_SEL_MOD   = 2'b01;
  localparam logic [1:0] OUT_SEL_DEMOD = 2'b10;
  localparam logic [1:0] OUT_SEL_BLANK = 2'b11;

  localparam logic [1:0] WAVE_NCO   = 2'b00;
  localparam logic [1:0] WAVE_CHIRP = 2'b01;
  localparam logic [1:0] WAVE_SAW   = 2'b10;
  localparam logic [1:0] WAVE_PULSE = 2'b11;

  localparam int WAVE_W  = 2;
  localparam int OSEL_W  = 2;
  localparam int FREQ_W  = 32;
  localparam int DWELL_W = 16;
  localparam int GUARD_W = 8;
  localparam int PROF_W  = WAVE_W + OSEL_W + FREQ_W + DWELL_W;

  typedef struct packed {
    logic [WAVE_W-1:0]  wave_sel;
    logic [OSEL_W-1:0]  out_sel;
    logic [FREQ_W-1:0]  freq;
    logic [DWELL_W-1:0] dwell;
  } prof_t;

  function automatic logic [DWELL_W-1:0] min1_dwell(
    input logic [DWELL_W-1:0] v
  );
    return (v == '0) ? DWELL_W'(1) : v;
  endfunction

  function automatic logic [GUARD_W-1:0] min1_guard(
    input logic [GUARD_W-1:0] v
  );
    return (v == '0) ? GUARD_W'(1) : v;
  endfunction

endpackage

// File: rtl/mawg_sequencer_if.sv
// Profile table write bus of the sequencer.
// master drives the write strobe/address/fields; slave is the sequencer.
interface mawg_sequencer_if #(
  parameter int AW = 3
);
  import mawg_pkg::*;

  logic               prof_we;
  logic [AW-1:0]      prof_addr;
  logic [WAVE_W-1:0]  prof_wave_sel;
  logic [OSEL_W-1:0]  prof_out_sel;
  logic [FREQ_W-1:0]  prof_freq;
  logic [DWELL_W-1:0] prof_dwell;

  modport master (
    output prof_we, prof_addr,
    output prof_wave_sel, prof_out_sel,
    output prof_freq, prof_dwell
  );

  modport slave (
    input prof_we, prof_addr,
    input prof_wave_sel, prof_out_sel,
    input prof_freq, prof_dwell
  );

endinterface

// File: rtl/mawg_profile_ram.sv
// Profile table: PROFILES x 52-bit registers, one write port,
// one asynchronous read port (read sees old data on same-cycle write).
module mawg_profile_ram
  import mawg_pkg::*;
#(
  parameter int PROFILES = 8,
  parameter int AW = $clog2(PROFILES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  prof_t         wdata,
  input  logic [AW-1:0] raddr,
  output prof_t         rdata
);

  prof_t mem [PROFILES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mawg_sequencer.sv
// Steps through profiles: blanked guard, then dwell, optional loop.
// Ports: clk/rst, table bus pif, run controls in, generator controls out.
module mawg_sequencer
  import mawg_pkg::*;
#(
  parameter int PROFILES = 8,
  parameter int AW = $clog2(PROFILES)
) (
  input  logic                clk,
  input  logic                rst,
  mawg_sequencer_if.slave     pif,
  input  logic [GUARD_W-1:0]  guard_len,
  input  logic [AW-1:0]       last_idx,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
  output logic [OSEL_W-1:0]   out_sel,
  output logic [WAVE_W-1:0]   wave_sel,
  output logic [FREQ_W-1:0]   freq_ctrl,
  output logic [AW-1:0]       cur_idx,
  output logic                busy,
  output logic                done
);

  state_t             state;
  prof_t              wdata;
  prof_t              rdata;
  logic [AW-1:0]      ld_addr;
  logic [AW-1:0]      last_q;
  logic               loop_q;
  logic [GUARD_W-1:0] gcnt;
  logic [DWELL_W-1:0] dcnt;
  logic [DWELL_W-1:0] sh_dwell;
  logic [OSEL_W-1:0]  sh_out;
  logic               do_load;
  logic               g_last;
  logic               d_last;

  assign wdata = {pif.prof_wave_sel, pif.prof_out_sel,
                  pif.prof_freq, pif.prof_dwell};

  mawg_profile_ram #(
    .PROFILES (PROFILES),
    .AW       (AW)
  ) u_ram (
    .clk   (clk),
    .we    (pif.prof_we),
    .waddr (pif.prof_addr),
    .wdata (wdata),
    .raddr (ld_addr),
    .rdata (rdata)
  );

  assign g_last = (gcnt == GUARD_W'(1));
  assign d_last = (dcnt == DWELL_W'(1));

  // Next profile index and whether a load happens this cycle.
  always_comb begin
    do_load = 1'b0;
    ld_addr = '0;
    unique case (state)
      ST_IDLE: do_load = start && !stop;
      ST_DWELL: begin
        do_load = !stop && d_last &&
                  ((cur_idx != last_q) || loop_q);
        ld_addr = (cur_idx == last_q) ? '0
                                      : cur_idx + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_sel   <= OUT_SEL_BLANK;
      wave_sel  <= '0;
      freq_ctrl <= '0;
      cur_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      gcnt      <= GUARD_W'(1);
      dcnt      <= DWELL_W'(1);
      sh_dwell  <= '0;
      sh_out    <= OUT_SEL_BLANK;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (do_load) begin
            last_q <= last_idx;
            loop_q <= loop_en;
            busy   <= 1'b1;
            state  <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (stop) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            out_sel <= OUT_SEL_BLANK;
          end else if (g_last) begin
            out_sel <= sh_out;
            dcnt    <= min1_dwell(sh_dwell);
            state   <= ST_DWELL;
          end else begin
            gcnt <= gcnt - GUARD_W'(1);
          end
        end
        ST_DWELL: begin
          if (stop) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            out_sel <= OUT_SEL_BLANK;
          end else if (do_load) begin
            state <= ST_GUARD;
          end else if (d_last) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            out_sel <= OUT_SEL_BLANK;
            done    <= 1'b1;
          end else begin
            dcnt <= dcnt - DWELL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Dwell and out_sel are shadowed so later table writes
      // cannot disturb the profile already in flight.
      if (do_load) begin
        wave_sel  <= rdata.wave_sel;
        freq_ctrl <= rdata.freq;
        out_sel   <= OUT_SEL_BLANK;
        cur_idx   <= ld_addr;
        gcnt      <= min1_guard(guard_len);
        sh_out    <= rdata.out_sel;
        sh_dwell  <= rdata.dwell;
      end
    end
  end

endmodule

// File: tb/tb_mawg_sequencer.sv
// Scoreboard bench for mawg_sequencer: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_mawg_sequencer;
  import mawg_pkg::*;

  localparam int PROFILES = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    guard_len = 8'd2;
  logic [AW-1:0] last_idx = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    out_sel;
  logic [1:0]    wave_sel;
  logic [31:0]   freq_ctrl;
  logic [AW-1:0] cur_idx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mawg_sequencer_if #(.AW(AW)) pif ();

  mawg_sequencer #(
    .PROFILES (PROFILES),
    .AW       (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pif       (pif.slave),
    .guard_len (guard_len),
    .last_idx  (last_idx),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .out_sel   (out_sel),
    .wave_sel  (wave_sel),
    .freq_ctrl (freq_ctrl),
    .cur_idx   (cur_idx),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int            tag;
    logic [1:0]    os;
    logic [1:0]    ws;
    logic [31:0]   fq;
    logic [AW-1:0] idx;
    logic          b;
    logic          d;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (out_sel !== e.os || wave_sel !== e.ws ||
          freq_ctrl !== e.fq || cur_idx !== e.idx ||
          busy !== e.b || done !== e.d) begin
        errors++;
        $display("FAIL test%0d: got os=%b ws=%b fq=%h idx=%0d busy=%b done=%b want os=%b ws=%b fq=%h idx=%0d busy=%b done=%b",
                 e.tag, out_sel, wave_sel, freq_ctrl, cur_idx,
                 busy, done, e.os, e.ws, e.fq, e.idx, e.b, e.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expn(input int tag, input logic [1:0] os,
                      input logic [1:0] ws, input logic [31:0] fq,
                      input logic [AW-1:0] idx, input logic b,
                      input logic d, input int n);
    exp_t e;
    e.tag = tag; e.os = os; e.ws = ws; e.fq = fq;
    e.idx = idx; e.b = b; e.d = d;
    repeat (n) q.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 300) begin
      cyc();
      k++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] ws,
                    input logic [1:0] os, input logic [31:0] fq,
                    input logic [15:0] dw);
    pif.prof_addr     = a;
    pif.prof_wave_sel = ws;
    pif.prof_out_sel  = os;
    pif.prof_freq     = fq;
    pif.prof_dwell    = dw;
    pif.prof_we       = 1'b1;
    cyc();
    pif.prof_we       = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.prof_we = 1'b0;
    pif.prof_addr = '0;
    pif.prof_wave_sel = '0;
    pif.prof_out_sel = '0;
    pif.prof_freq = '0;
    pif.prof_dwell = '0;

    // 1: reset state
    cyc();
    expn(1, 2'b11, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0, 2);
    drain();
    rst = 1'b0;

    wr(3'd0, 2'b00, 2'b00, 32'h100, 16'd4);
    wr(3'd1, 2'b01, 2'b01, 32'h200, 16'd5);
    wr(3'd2, 2'b10, 2'b10, 32'h300, 16'd6);

    // 2: basic 3-profile run
    guard_len = 8'd2; last_idx = 3'd2; loop_en = 1'b0;
    go();
    expn(2, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    expn(2, 2'b00, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 4);
    expn(2, 2'b11, 2'b01, 32'h200, 3'd1, 1'b1, 1'b0, 2);
    expn(2, 2'b01, 2'b01, 32'h200, 3'd1, 1'b1, 1'b0, 5);
    expn(2, 2'b11, 2'b10, 32'h300, 3'd2, 1'b1, 1'b0, 2);
    expn(2, 2'b10, 2'b10, 32'h300, 3'd2, 1'b1, 1'b0, 6);
    expn(2, 2'b11, 2'b10, 32'h300, 3'd2, 1'b0, 1'b1, 1);
    expn(2, 2'b11, 2'b10, 32'h300, 3'd2, 1'b0, 1'b0, 2);
    drain();

    // 3: reset mid-dwell, table survives, stop in dwell
    go();
    expn(3, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    expn(3, 2'b00, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    drain();
    rst = 1'b1;
    cyc();
    expn(3, 2'b11, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0, 1);
    drain();
    rst = 1'b0;
    go();
    expn(3, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    drain();
    halt();
    expn(3, 2'b11, 2'b00, 32'h100, 3'd0, 1'b0, 1'b0, 2);
    drain();

    // 4: stop+start collision in guard of profile 1
    go();
    expn(4, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    expn(4, 2'b00, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 4);
    expn(4, 2'b11, 2'b01, 32'h200, 3'd1, 1'b1, 1'b0, 1);
    drain();
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    expn(4, 2'b11, 2'b01, 32'h200, 3'd1, 1'b0, 1'b0, 3);
    drain();
    go();
    expn(4, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    drain();
    halt();
    expn(4, 2'b11, 2'b00, 32'h100, 3'd0, 1'b0, 1'b0, 1);
    drain();

    // 5: write to active entry mid-dwell, looping run
    last_idx = 3'd1; loop_en = 1'b1;
    go();
    expn(5, 2'b11, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    expn(5, 2'b00, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 2);
    drain();
    wr(3'd0, 2'b00, 2'b00, 32'h1234_5678, 16'd4);
    expn(5, 2'b00, 2'b00, 32'h100, 3'd0, 1'b1, 1'b0, 1);
    expn(5, 2'b11, 2'b01, 32'h200, 3'd1, 1'b1, 1'b0, 2);
    expn(5, 2'b01, 2'b01, 32'h200, 3'd1, 1'b1, 1'b0, 5);
    expn(5, 2'b11, 2'b00, 32'h1234_5678, 3'd0, 1'b1, 1'b0, 2);
    expn(5, 2'b00, 2'b00, 32'h1234_5678, 3'd0, 1'b1, 1'b0, 4);
    drain();
    halt();
    expn(5, 2'b11, 2'b01, 32'h200, 3'd1, 1'b0, 1'b0, 1);
    drain();

    // 6: looping with zero guard and dwell
    wr(3'd0, 2'b11, 2'b00, 32'hAA, 16'd0);
    wr(3'd1, 2'b01, 2'b01, 32'hBB, 16'd0);
    guard_len = 8'd0; last_idx = 3'd1; loop_en = 1'b1;
    go();
    for (int i = 0; i < 3; i++) begin
      expn(6, 2'b11, 2'b11, 32'hAA, 3'd0, 1'b1, 1'b0, 1);
      expn(6, 2'b00, 2'b11, 32'hAA, 3'd0, 1'b1, 1'b0, 1);
      expn(6, 2'b11, 2'b01, 32'hBB, 3'd1, 1'b1, 1'b0, 1);
      expn(6, 2'b01, 2'b01, 32'hBB, 3'd1, 1'b1, 1'b0, 1);
    end
    drain();
    halt();
    expn(6, 2'b11, 2'b11, 32'hAA, 3'd0, 1'b0, 1'b0, 1);
    drain();

    // 7: start held through the run, restart in done cycle
    loop_en = 1'b0;
    start = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      expn(7, 2'b11, 2'b11, 32'hAA, 3'd0, 1'b1, 1'b0, 1);
      expn(7, 2'b00, 2'b11, 32'hAA, 3'd0, 1'b1, 1'b0, 1);
      expn(7, 2'b11, 2'b01, 32'hBB, 3'd1, 1'b1, 1'b0, 1);
      expn(7, 2'b01, 2'b01, 32'hBB, 3'd1, 1'b1, 1'b0, 1);
      expn(7, 2'b11, 2'b01, 32'hBB, 3'd1, 1'b0, 1'b1, 1);
    end
    drain();
    start = 1'b0;
    halt();
    expn(7, 2'b11, 2'b11, 32'hAA, 3'd0, 1'b0, 1'b0, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
